// File: rtl/echo_unit.sv
// Feedback echo: mixes each sample with a decayed copy of an earlier output.
// Wet output is kept in a single-port circular buffer swept to zero on clear.
module echo_unit #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [15:0]           sample_in,
    input  logic                  sample_in_valid,
    input  logic [ADDR_WIDTH-1:0] delay_samples,
    input  logic [1:0]            decay,
    output logic [15:0]           sample_out,
    output logic                  sample_out_valid,
    output logic                  ready,
    output logic                  overrun
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_MIX,
        S_WRITE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] dly_q;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [1:0]            decay_q;
    logic signed [15:0]    dry_q;
    logic signed [15:0]    rd_data;
    logic signed [15:0]    wet;
    logic signed [15:0]    mix;
    logic signed [16:0]    sum;
    logic [15:0]           ram_wdata;
    logic                  ram_we;
    logic                  busy;

    logic signed [15:0] mem [2**ADDR_WIDTH];

    assign ready = (state == S_IDLE);
    assign busy  = (state == S_READ) || (state == S_MIX)
                || (state == S_WRITE);

    always_comb begin
        state_nx = state;
        case (state)
            S_CLEAR: if (clr_ptr == LAST) state_nx = S_IDLE;
            S_IDLE:  if (sample_in_valid) state_nx = S_READ;
            S_READ:  state_nx = S_MIX;
            S_MIX:   state_nx = S_WRITE;
            S_WRITE: state_nx = S_IDLE;
            default: state_nx = S_CLEAR;
        endcase
        if (clear) state_nx = S_CLEAR;
    end

    // One port access per cycle: sweep write, echo read or mix write.
    always_comb begin
        ram_addr  = wr_ptr;
        ram_wdata = '0;
        ram_we    = 1'b0;
        case (state)
            S_CLEAR: begin
                ram_addr = clr_ptr;
                ram_we   = !reset && !clear;
            end
            S_READ:  ram_addr = wr_ptr - dly_q;
            S_WRITE: begin
                ram_wdata = sample_out;
                ram_we    = !reset && !clear;
            end
            default: ram_addr = wr_ptr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        rd_data <= mem[ram_addr];
    end

    always_comb begin
        wet = rd_data >>> decay_q;
        sum = {dry_q[15], dry_q} + {wet[15], wet};
        mix = sum[15:0];
        if (sum[16:15] == 2'b01) mix = 16'sh7fff;
        if (sum[16:15] == 2'b10) mix = -16'sh8000;
        if (decay_q == 2'd0 || dly_q == '0) mix = dry_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_CLEAR;
            clr_ptr          <= '0;
            wr_ptr           <= '0;
            dly_q            <= '0;
            decay_q          <= '0;
            dry_q            <= '0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            state            <= state_nx;
            sample_out_valid <= 1'b0;
            if (state == S_CLEAR && !clear)
                clr_ptr <= clr_ptr + ONE;
            else
                clr_ptr <= '0;
            if (sample_in_valid && busy && !clear)
                overrun <= 1'b1;
            if (state == S_IDLE && sample_in_valid && !clear) begin
                dry_q   <= sample_in;
                dly_q   <= delay_samples;
                decay_q <= decay;
            end
            // Output registers on leaving MIX so the strobe shows in WRITE.
            if (state == S_MIX && !clear) begin
                sample_out       <= mix;
                sample_out_valid <= 1'b1;
            end
            if (state == S_WRITE && !clear)
                wr_ptr <= wr_ptr + ONE;
        end
    end

endmodule

// File: doc/echo_unit.md
# echo_unit

Feedback echo stage between the note distributor's sample output and the codec conditioner. Each accepted 16-bit sample is mixed with an attenuated copy of the output from `delay_samples` samples earlier, saturated, and presented as a new sample with a one-cycle valid strobe. The unit keeps its mixed output in a single-port circular buffer. `sample_out_valid` drives the codec conditioner's `latch_new_sample_in`, and `clear` is driven by the player reset so echoes do not carry across songs.

## Interface
- `ADDR_WIDTH`, default 12: buffer depth is 2^ADDR_WIDTH samples, and this is the maximum delay.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: synchronous, active-high. Resets all state and starts the buffer clear sweep.
- `clear` input, 1 bit: synchronous, active-high. Aborts any operation in progress and starts the buffer clear sweep. `overrun` is not cleared.
- `sample_in` input, 16 bits: signed two's-complement dry sample.
- `sample_in_valid` input, 1 bit: one-cycle strobe marking `sample_in` as new.
- `delay_samples` input, ADDR_WIDTH bits: echo delay in samples. Sampled when a sample is accepted.
- `decay` input, 2 bits: 0 means bypass; 1, 2 and 3 mean the delayed sample is arithmetic-shifted right by 1, 2 and 3. Sampled when a sample is accepted.
- `sample_out` output, 16 bits: signed wet sample. Registered and held between updates.
- `sample_out_valid` output, 1 bit: one-cycle strobe, high when `sample_out` updates.
- `ready` output, 1 bit: high only in IDLE.
- `overrun` output, 1 bit: sticky. Set when a valid sample arrives while `ready` is low outside CLEAR.

## Operation
- FSM states and transitions:
  - CLEAR: write 0 to address `clr_ptr`, incrementing `clr_ptr` each cycle. After address 2^ADDR_WIDTH−1 is written, go to IDLE.
  - IDLE: on `sample_in_valid`, latch the sample, `delay_samples` and `decay`, then go to READ.
  - READ: drive the read address `rd_addr = wr_ptr − delay_samples` (mod 2^ADDR_WIDTH), then go to MIX.
  - MIX: the registered read data is valid. Compute `mix`, then go to WRITE.
  - WRITE: register `mix` into `sample_out`, pulse `sample_out_valid`, write `mix` to `wr_ptr`, increment `wr_ptr` (wrapping), then go to IDLE.
- Mix arithmetic:
  - `wet = delayed >>> decay`, signed, so the result floors toward −∞.
  - `sum = sext17(dry) + sext17(wet)`.
  - `mix` is `sum` saturated to the range −32768..32767.
  - If `decay == 0` or `delay_samples == 0`, then `mix = dry`, but the buffer is still read and written.
- Feedback: because the buffer stores `mix` rather than `dry`, an impulse repeats every `delay_samples` samples, halving in amplitude per repeat when `decay = 1`.
- `sample_in_valid` is ignored while in READ, MIX or WRITE (`overrun` is set), and ignored in CLEAR (`overrun` is not set).
- `reset` and `clear` take priority over everything else, including a simultaneous `sample_in_valid`. That sample is dropped and no `sample_out_valid` is produced.
- A `clear` asserted mid-operation, in READ, MIX or WRITE, abandons that sample: no output strobe, and no buffer write of `mix`. The FSM enters CLEAR the next cycle.
- Buffer: single-port synchronous RAM of 2^ADDR_WIDTH × 16, with read data registered. There is one port access per cycle: CLEAR writes, READ reads, WRITE writes.

## Timing
- Reset values:
  - `sample_out` = 0, `sample_out_valid` = 0, `ready` = 0, `overrun` = 0.
  - `wr_ptr` = 0, `clr_ptr` = 0, state = CLEAR.
- After `reset` or `clear` deasserts, `ready` rises exactly 2^ADDR_WIDTH cycles later.
- Latency:
  - With `sample_in_valid` high in cycle T while in IDLE, `sample_out_valid` is high in cycle T+3, with `sample_out` valid from T+3 on.
  - `ready` is low during T+1..T+3 and high again in T+4.
  - Minimum input spacing is 4 cycles. At 48 kHz the spacing is more than 1000 cycles, so overrun indicates a system fault.
- The buffer write in WRITE is visible to a READ no earlier than the next accepted sample.

## Test plan
- Reset with ADDR_WIDTH=4 → `ready` is 0 for 16 cycles after `reset` falls, then 1. `sample_out` = 0 and `overrun` = 0. Every output for zero input is 0.
- Impulse test with `delay_samples`=4 and `decay`=1: input 16000 followed by zeros → output sequence 16000, 0, 0, 0, 8000, 0, 0, 0, 4000, …, then 2000. Each output appears 3 cycles after its input strobe.
- Saturation and sign, with `delay_samples`=1 and `decay`=1:
  - Inputs 30000, 30000 → outputs 30000, then 32767.
  - Inputs −32768, −32768 → −32768, then −32768.
  - Input −3 after a stored −3 → −5, since −3 >>> 1 = −2.
- Bypass with `decay`=0 and random inputs → `sample_out` equals `sample_in` on every strobe. Switching to `decay`=1 with `delay_samples`=2 then echoes the bypassed samples from 2 samples earlier at half amplitude.
- Overrun: a second `sample_in_valid` 2 cycles after the first → it is ignored, only one output strobe appears, and `overrun` goes to 1 and stays there through `clear`. Only `reset` returns it to 0.
- `clear` asserted in MIX → no output strobe, 16-cycle sweep, then an impulse with `delay_samples`=4 and `decay`=1 produces no residue from before the clear. The stale stored value returns 0.
